// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SCAN,
    MUL,
    SQR,
    DONE
  } modexp_state_t;

  function automatic logic is_mult_state(input modexp_state_t s);
    return (s == REDUCE) || (s == MUL) || (s == SQR);
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n, one bit of a per cycle.
// Requires b < n; a may be arbitrary. done pulses WIDTH cycles after the start cycle.
module mod_mult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a, r_b, r_n, r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;

  logic [WIDTH-1:0] w_src_acc, w_src_b, w_src_n, w_step;
  logic             w_src_bit;
  logic [WIDTH+1:0] w_sum, w_sub1, w_n_ext;

  // The start edge already performs the first step on the live inputs.
  always_comb begin
    w_src_acc = start ? '0 : r_acc;
    w_src_bit = start ? a[WIDTH-1] : r_a[WIDTH-1];
    w_src_b   = start ? b : r_b;
    w_src_n   = start ? n : r_n;
    w_n_ext   = {2'b00, w_src_n};
    w_sum     = {1'b0, w_src_acc, 1'b0} + (w_src_bit ? {2'b00, w_src_b} : '0);
    w_sub1    = (w_sum >= w_n_ext) ? w_sum - w_n_ext : w_sum;
    w_step    = WIDTH'((w_sub1 >= w_n_ext) ? w_sub1 - w_n_ext : w_sub1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc  <= w_step;
        r_a    <= {a[WIDTH-2:0], 1'b0};
        r_b    <= b;
        r_n    <= n;
        r_cnt  <= CW'(WIDTH - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_step;
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign p    = r_acc;
  assign done = r_done;

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply controller computing base^exp mod modulus
// on a single shared iterative modular multiplier.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH     = RSA_WIDTH,
  parameter int unsigned EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 err
);

  modexp_state_t r_state, w_state_d;

  logic [WIDTH-1:0]     r_b, r_n, r_acc, r_result;
  logic [EXP_WIDTH-1:0] r_e;
  logic                 r_err, r_mm_start;

  logic [WIDTH-1:0] w_mm_a, w_mm_b, w_mm_p;
  logic             w_mm_done;

  mod_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .start(r_mm_start),
    .a    (w_mm_a),
    .b    (w_mm_b),
    .n    (r_n),
    .p    (w_mm_p),
    .done (w_mm_done)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d = (modulus <= WIDTH'(1)) ? DONE : REDUCE;
        end
      end
      REDUCE, MUL, SQR: begin
        if (w_mm_done) w_state_d = SCAN;
      end
      SCAN: begin
        if (r_e == '0)    w_state_d = DONE;
        else if (r_e[0])  w_state_d = MUL;
        else              w_state_d = SQR;
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // REDUCE multiplies the raw base by 1 so every later operand is already < n.
  always_comb begin
    w_mm_a = r_b;
    w_mm_b = r_b;
    case (r_state)
      REDUCE:  w_mm_b = WIDTH'(1);
      MUL:     w_mm_a = r_acc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_b        <= '0;
      r_n        <= '0;
      r_e        <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_mm_start <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_mm_start <= is_mult_state(w_state_d) && !is_mult_state(r_state);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_b   <= base;
            r_e   <= exp;
            r_n   <= modulus;
            r_acc <= WIDTH'(1);
            r_err <= (modulus == '0);
            if (modulus <= WIDTH'(1)) r_result <= '0;
          end
        end
        REDUCE: begin
          if (w_mm_done) r_b <= w_mm_p;
        end
        MUL: begin
          if (w_mm_done) begin
            r_acc  <= w_mm_p;
            r_e[0] <= 1'b0;
          end
        end
        SQR: begin
          if (w_mm_done) begin
            r_b <= w_mm_p;
            r_e <= r_e >> 1;
          end
        end
        SCAN: begin
          if (r_e == '0) r_result <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign ready  = (r_state == IDLE);
  assign done   = (r_state == DONE);
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: directed vectors, corner sequences and random runs.
module tb_modexp_ctrl;

  localparam int W  = 8;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst, start, ready, done, err;
  logic [W-1:0]  b_v, n_v, result;
  logic [EW-1:0] e_v;

  int checks = 0;
  int errors = 0;

  modexp_ctrl #(
    .WIDTH    (W),
    .EXP_WIDTH(EW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ready  (ready),
    .base   (b_v),
    .exp    (e_v),
    .modulus(n_v),
    .result (result),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int e;
    int n;
    int res;
    int lat;
    int er;
  } vec_t;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint model_pow(input longint b, input longint e, input longint n);
    longint r, bb;
    if (n <= 1) return 0;
    r  = 1;
    bb = b % n;
    for (int i = 0; i < EW; i++) begin
      if (((e >> i) & 1) == 1) r = (r * bb) % n;
      bb = (bb * bb) % n;
    end
    return r;
  endfunction

  function automatic int model_k(input longint e);
    int pc = 0;
    int bl = 0;
    for (int i = 0; i < EW; i++) begin
      if (((e >> i) & 1) == 1) begin
        pc++;
        bl = i + 1;
      end
    end
    return pc + ((bl > 0) ? bl - 1 : 0);
  endfunction

  function automatic int model_lat(input longint e, input longint n);
    if (n <= 1) return 1;
    return (W + 2) * (model_k(e) + 1) + 1;
  endfunction

  // Presents one request once the DUT is idle; returns at cycle 1 (just after the accept edge).
  task automatic issue(input int b, input int e, input int n);
    @(negedge clk);
    for (int i = 0; i < 5 && !ready; i++) @(negedge clk);
    b_v   = W'(b);
    e_v   = EW'(e);
    n_v   = W'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    b_v   = W'($urandom);
    e_v   = EW'($urandom);
    n_v   = W'($urandom);
  endtask

  // Walks cycles from 1 until done, stopping in the done cycle; lat=-1 on timeout.
  task automatic wait_done(input int poke_cyc, output int lat, output int mm, output int rdy_bad);
    int cyc = 1;
    lat     = -1;
    mm      = 0;
    rdy_bad = 0;
    while (cyc < 3000) begin
      if (dut.u_mult.start) mm++;
      if (ready) rdy_bad++;
      if (done) begin
        lat = cyc;
        break;
      end
      if (cyc == poke_cyc) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic run_vec(input string name, input int b, input int e, input int n, input int res,
                         input int lat_exp, input int er, input int mm_exp);
    int lat, mm, rdy_bad;
    issue(b, e, n);
    wait_done(0, lat, mm, rdy_bad);
    check({name, " latency"}, lat, lat_exp);
    check({name, " result"}, result, res);
    check({name, " err"}, err, er);
    check({name, " ready low while busy"}, rdy_bad, 0);
    if (mm_exp >= 0) check({name, " mult starts"}, mm, mm_exp);
  endtask

  vec_t vecs[6];

  initial begin
    int lat, mm, rdy_bad, extra;
    int rb, re, rn;

    vecs[0] = '{b: 2,   e: 7,  n: 33, res: 29, lat: 61, er: 0};
    vecs[1] = '{b: 29,  e: 3,  n: 33, res: 2,  lat: 41, er: 0};
    vecs[2] = '{b: 4,   e: 13, n: 33, res: 31, lat: 71, er: 0};
    vecs[3] = '{b: 200, e: 0,  n: 33, res: 1,  lat: 11, er: 0};
    vecs[4] = '{b: 5,   e: 9,  n: 1,  res: 0,  lat: 1,  er: 0};
    vecs[5] = '{b: 5,   e: 9,  n: 0,  res: 0,  lat: 1,  er: 1};

    rst   = 1'b1;
    start = 1'b0;
    b_v   = '0;
    e_v   = '0;
    n_v   = '0;
    #1;
    check("reset ready", ready, 1);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset result", result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].n, vecs[i].res,
              vecs[i].lat, vecs[i].er, (i == 2) ? 7 : -1);
    end

    // Stray start during a busy run must neither queue nor produce a second done.
    issue(2, 7, 33);
    wait_done(20, lat, mm, rdy_bad);
    check("poke latency", lat, 61);
    check("poke result", result, 29);
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("poke extra done", extra, 0);
    check("poke idle after", ready, 1);

    // Start raised in the done cycle is taken at the first edge with the DUT idle.
    issue(2, 7, 33);
    wait_done(0, lat, mm, rdy_bad);
    check("b2b first latency", lat, 61);
    b_v   = W'(29);
    e_v   = EW'(3);
    n_v   = W'(33);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b idle ready", ready, 1);
    check("b2b idle done", done, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    b_v   = '0;
    check("b2b accepted", ready, 0);
    wait_done(0, lat, mm, rdy_bad);
    check("b2b second latency", lat, 41);
    check("b2b second result", result, 2);

    // Asynchronous reset in the middle of the first SQR (cycles 21..29).
    issue(2, 7, 33);
    repeat (24) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort ready", ready, 1);
    check("abort done", done, 0);
    check("abort result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("after abort", 2, 7, 33, 29, 61, 0, 6);

    for (int t = 0; t < 30; t++) begin
      rb = int'($urandom_range(0, 255));
      rn = int'($urandom_range(0, 255));
      if (t < 3) rn = t;
      re = (t % 3 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
      run_vec($sformatf("rand%0d b=%0d e=%0d n=%0d", t, rb, re, rn), rb, re, rn,
              int'(model_pow(rb, re, rn)), model_lat(re, rn), (rn == 0) ? 1 : 0,
              (rn <= 1) ? 0 : model_k(re) + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
